ex_stage_alu: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its control fields (EX1/EX2/EX3), operands, sign-extended immediate and register specifiers.
- Applies operand forwarding, computes single-cycle ALU results and runs a multi-cycle shift-add multiplier.
- Produces the ALU result and destination register for EX/MEM.
- Drives the pipeline-enable (pcEnable) low while a multiply is in flight.

---
 rtl/ex_stage_alu_pkg.sv | 34 +++
 rtl/ex_stage_alu_if.sv | 38 +++
 rtl/ex_stage_alu_seq_multiplier.sv | 98 +++++++++
 rtl/ex_stage_alu.sv | 97 +++++++++
 tb/tb_ex_stage_alu.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_alu_pkg.sv
// ex_stage_alu_pkg
// Shared encodings for the MIPS execute stage: ALU-op (EX2) codes, R-type
// funct codes, forwarding-select codes and the multiplier FSM state type.
package ex_stage_alu_pkg;

   // EX2 control field from ID/EX
   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_RTYPE = 2'b10,
      ALU_OR    = 2'b11
   } alu_op_e;

   // R-type funct field (low six bits of the sign-extended immediate)
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [5:0] FUNCT_MUL = 6'b011000;

   // Forwarding mux selects; 2'b11 is unused and behaves like FWD_ID
   localparam logic [1:0] FWD_ID    = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

   // Sequential multiplier states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } mul_state_e;

endpackage

// File: rtl/ex_stage_alu_if.sv
// ex_stage_alu_if
// Bundles the ID/EX control, operand and forwarding inputs of the execute
// stage together with its EX/MEM-facing outputs and stall indication.
//   master : pipeline side (drives ID/EX fields, observes results)
//   slave  : execute stage (consumes ID/EX fields, drives results)
interface ex_stage_alu_if #(
   parameter int WIDTH = 32
);
   logic             alu_src_i;
   logic [1:0]       alu_op_i;
   logic             reg_dst_i;
   logic [WIDTH-1:0] data1_i;
   logic [WIDTH-1:0] data2_i;
   logic [WIDTH-1:0] sign_extend_i;
   logic [4:0]       inst20_16_i;
   logic [4:0]       inst15_11_i;
   logic [1:0]       fwd_a_i;
   logic [1:0]       fwd_b_i;
   logic [WIDTH-1:0] exmem_data_i;
   logic [WIDTH-1:0] memwb_data_i;
   logic [WIDTH-1:0] result_o;
   logic [WIDTH-1:0] write_data_o;
   logic [4:0]       write_reg_o;
   logic             pc_enable_o;
   logic             mul_busy_o;

   modport master (
      output alu_src_i, alu_op_i, reg_dst_i, data1_i, data2_i, sign_extend_i,
             inst20_16_i, inst15_11_i, fwd_a_i, fwd_b_i, exmem_data_i, memwb_data_i,
      input  result_o, write_data_o, write_reg_o, pc_enable_o, mul_busy_o
   );

   modport slave (
      input  alu_src_i, alu_op_i, reg_dst_i, data1_i, data2_i, sign_extend_i,
             inst20_16_i, inst15_11_i, fwd_a_i, fwd_b_i, exmem_data_i, memwb_data_i,
      output result_o, write_data_o, write_reg_o, pc_enable_o, mul_busy_o
   );
endinterface

// File: rtl/ex_stage_alu_seq_multiplier.sv
// seq_multiplier
// Shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per cycle.
// Operands are captured when i_start is seen in IDLE; the product (low WIDTH
// bits) is valid only while o_done is high, for exactly one cycle.
//   clk_i      clock
//   rst_i      asynchronous active-low reset
//   i_start    begin a multiply (ignored unless IDLE)
//   i_mcand    multiplicand
//   i_mplier   multiplier
//   o_busy     state is BUSY or DONE
//   o_done     state is DONE, o_product valid
//   o_product  accumulated product
module seq_multiplier
   import ex_stage_alu_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_mcand,
   input  logic [WIDTH-1:0] i_mplier,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_product
);
   localparam int MUL_CYCLES = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W      = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MUL_CYCLES - 1);

   mul_state_e       r_state;
   mul_state_e       w_state_next;
   logic             w_load;
   logic             w_step;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [CNT_W-1:0] r_cnt;

   // Partial product for this step: sum of shifted multiplicands selected by
   // the low BITS_PER_CYCLE multiplier bits, built as an adder chain.
   logic [WIDTH-1:0] w_pp [BITS_PER_CYCLE+1];
   assign w_pp[0] = '0;
   for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
      assign w_pp[gi+1] = w_pp[gi] + (r_mplier[gi] ? (r_mcand << gi) : '0);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_step       = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_load       = 1'b1;
               w_state_next = BUSY;
            end
         end
         BUSY: begin
            w_step = 1'b1;
            if (r_cnt == '0) w_state_next = DONE;
         end
         // Always return to IDLE so the still-held mul is not restarted
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else if (w_load) begin
         r_acc    <= '0;
         r_mcand  <= i_mcand;
         r_mplier <= i_mplier;
         r_cnt    <= CNT_MAX;
      end else if (w_step) begin
         r_acc    <= r_acc + w_pp[BITS_PER_CYCLE];
         r_mcand  <= r_mcand << BITS_PER_CYCLE;
         r_mplier <= r_mplier >> BITS_PER_CYCLE;
         if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_busy    = (r_state != IDLE);
   assign o_done    = (r_state == DONE);
   assign o_product = r_acc;

endmodule

// File: rtl/ex_stage_alu.sv
// ex_stage_alu
// Execute stage of the 5-stage MIPS pipeline: operand forwarding muxes,
// single-cycle ALU, destination register select and a sequential multiplier
// that freezes the front of the pipeline while it runs.
//   clk_i  clock
//   rst_i  asynchronous active-low reset
//   bus    ex_stage_alu_if.slave: ID/EX fields, forwarding data, results
module ex_stage_alu
   import ex_stage_alu_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   ex_stage_alu_if.slave bus
);
   logic [WIDTH-1:0] w_op_a;
   logic [WIDTH-1:0] w_rt_fwd;
   logic [WIDTH-1:0] w_op_b;
   logic [WIDTH-1:0] w_alu;
   logic             w_is_mul;
   logic             w_mul_busy;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_product;
   logic             w_stall;
   logic [5:0]       w_funct;

   function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0]       sel,
                                                input logic [WIDTH-1:0] base,
                                                input logic [WIDTH-1:0] exmem,
                                                input logic [WIDTH-1:0] memwb);
      case (sel)
         FWD_EXMEM: return exmem;
         FWD_MEMWB: return memwb;
         default:   return base;
      endcase
   endfunction

   assign w_op_a   = fwd_mux(bus.fwd_a_i, bus.data1_i, bus.exmem_data_i, bus.memwb_data_i);
   assign w_rt_fwd = fwd_mux(bus.fwd_b_i, bus.data2_i, bus.exmem_data_i, bus.memwb_data_i);
   assign w_op_b   = bus.alu_src_i ? bus.sign_extend_i : w_rt_fwd;
   assign w_funct  = bus.sign_extend_i[5:0];

   always_comb begin
      w_alu    = '0;
      w_is_mul = 1'b0;
      case (alu_op_e'(bus.alu_op_i))
         ALU_ADD: w_alu = w_op_a + w_op_b;
         ALU_SUB: w_alu = w_op_a - w_op_b;
         ALU_OR:  w_alu = w_op_a | w_op_b;
         ALU_RTYPE: begin
            case (w_funct)
               FUNCT_ADD: w_alu = w_op_a + w_op_b;
               FUNCT_SUB: w_alu = w_op_a - w_op_b;
               FUNCT_AND: w_alu = w_op_a & w_op_b;
               FUNCT_OR:  w_alu = w_op_a | w_op_b;
               FUNCT_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
               FUNCT_MUL: w_is_mul = 1'b1;
               default:   w_alu = '0;
            endcase
         end
         default: w_alu = '0;
      endcase
   end

   seq_multiplier #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_mul (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .i_start   (w_is_mul),
      .i_mcand   (w_op_a),
      .i_mplier  (w_op_b),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_product)
   );

   // Stall from the cycle a mul is first decoded (IDLE) through the last
   // BUSY cycle; DONE releases the pipeline so the product is captured.
   assign w_stall = w_mul_busy ? ~w_mul_done : w_is_mul;

   assign bus.pc_enable_o  = ~rst_i | ~w_stall;
   assign bus.mul_busy_o   = w_mul_busy;
   assign bus.write_data_o = w_rt_fwd;
   assign bus.write_reg_o  = bus.reg_dst_i ? bus.inst15_11_i : bus.inst20_16_i;

   // Multiply results are shown only in DONE; the accumulator is never
   // exposed mid-computation.
   assign bus.result_o = !rst_i                       ? '0 :
                         w_mul_done                   ? w_product :
                         (w_is_mul || w_mul_busy)     ? '0 :
                                                        w_alu;

endmodule

// File: tb/tb_ex_stage_alu.sv
module tb_ex_stage_alu;

   localparam int W          = 32;
   localparam int MUL_CYCLES = 32;

   typedef struct {
      logic [1:0]  op;
      logic        src;
      logic        rdst;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [31:0] ex;
      logic [31:0] mw;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } stim_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   n_txn;
   logic [5:0] fpool [6];

   ex_stage_alu_if #(.WIDTH(W)) bus ();

   ex_stage_alu #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] base,
                                           input logic [31:0] ex, input logic [31:0] mw);
      if (sel == 2'b10) return ex;
      if (sel == 2'b01) return mw;
      return base;
   endfunction

   function automatic logic [31:0] ref_result(input stim_t s);
      logic [31:0] a, rtv, b;
      logic [63:0] prod;
      a   = ref_fwd(s.fa, s.d1, s.ex, s.mw);
      rtv = ref_fwd(s.fb, s.d2, s.ex, s.mw);
      b   = s.src ? s.imm : rtv;
      prod = 64'(a) * 64'(b);
      case (s.op)
         2'd0: return a + b;
         2'd1: return a - b;
         2'd3: return a | b;
         default: begin
            case (s.imm[5:0])
               6'd32: return a + b;
               6'd34: return a - b;
               6'd36: return a & b;
               6'd37: return a | b;
               6'd42: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
               6'd24: return prod[31:0];
               default: return 32'd0;
            endcase
         end
      endcase
   endfunction

   function automatic stim_t base_stim();
      stim_t s;
      s.op = 2'd0; s.src = 1'b0; s.rdst = 1'b1;
      s.d1 = '0; s.d2 = '0; s.imm = '0; s.fa = 2'd0; s.fb = 2'd0;
      s.ex = '0; s.mw = '0; s.rt = 5'd2; s.rd = 5'd3;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      bus.alu_op_i      = s.op;
      bus.alu_src_i     = s.src;
      bus.reg_dst_i     = s.rdst;
      bus.data1_i       = s.d1;
      bus.data2_i       = s.d2;
      bus.sign_extend_i = s.imm;
      bus.fwd_a_i       = s.fa;
      bus.fwd_b_i       = s.fb;
      bus.exmem_data_i  = s.ex;
      bus.memwb_data_i  = s.mw;
      bus.inst20_16_i   = s.rt;
      bus.inst15_11_i   = s.rd;
   endtask

   // Single-cycle op: drive, settle, compare every output against the model
   task automatic run_alu(input string tag, input stim_t s);
      logic [31:0] exp_wd;
      @(posedge clk); #1;
      apply(s);
      #1;
      exp_wd = ref_fwd(s.fb, s.d2, s.ex, s.mw);
      check_eq({tag, "/res"}, bus.result_o, ref_result(s));
      check_eq({tag, "/wdata"}, bus.write_data_o, exp_wd);
      check_eq({tag, "/wreg"}, 32'(bus.write_reg_o), 32'(s.rdst ? s.rd : s.rt));
      check_eq({tag, "/pcen"}, 32'(bus.pc_enable_o), 32'd1);
      n_txn++;
      $display("txn %0d %s op=%0d a=0x%08h b=0x%08h res=0x%08h", n_txn, tag, s.op,
               s.d1, s.d2, bus.result_o);
   endtask

   // Multiply: drive in the current cycle, count stall cycles, check product
   task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit flip);
      stim_t s;
      int    stall;
      s = base_stim();
      s.op = 2'd2; s.imm = 32'h0000_0018; s.d1 = a; s.d2 = b;
      apply(s);
      #1;
      check_eq({tag, "/stall0"}, 32'(bus.pc_enable_o), 32'd0);
      check_eq({tag, "/res0"}, bus.result_o, 32'd0);
      stall = 1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (bus.pc_enable_o) break;
         stall++;
         if (flip) begin
            bus.fwd_a_i      = 2'($urandom_range(3, 0));
            bus.fwd_b_i      = 2'($urandom_range(3, 0));
            bus.exmem_data_i = $urandom;
            bus.memwb_data_i = $urandom;
         end
      end
      check_eq({tag, "/stall_cycles"}, 32'(stall), 32'(MUL_CYCLES + 1));
      check_eq({tag, "/product"}, bus.result_o, ref_result(s));
      check_eq({tag, "/busy_done"}, 32'(bus.mul_busy_o), 32'd1);
      n_txn++;
      $display("txn %0d %s a=0x%08h b=0x%08h stall=%0d res=0x%08h", n_txn, tag, a, b,
               stall, bus.result_o);
   endtask

   initial begin
      stim_t s;
      logic [2:0] idx;
      n_checks = 0; n_fail = 0; n_txn = 0;
      fpool[0] = 6'h20; fpool[1] = 6'h22; fpool[2] = 6'h24;
      fpool[3] = 6'h25; fpool[4] = 6'h2a; fpool[5] = 6'h3f;

      // Reset state: a nonzero add is presented but result must read 0
      rst_n = 1'b0;
      s = base_stim(); s.d1 = 32'd5; s.d2 = 32'd7;
      apply(s);
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset/res", bus.result_o, 32'd0);
      check_eq("reset/pcen", 32'(bus.pc_enable_o), 32'd1);
      check_eq("reset/busy", 32'(bus.mul_busy_o), 32'd0);
      rst_n = 1'b1;

      // Directed single-cycle cases
      s = base_stim(); s.op = 2'd2; s.imm = 32'h22; s.d1 = 32'd5; s.d2 = 32'd7;
      run_alu("sub_5_7", s);
      s = base_stim(); s.op = 2'd2; s.imm = 32'h2a; s.d1 = 32'hFFFF_FFFF; s.d2 = 32'd1;
      run_alu("slt_m1_1", s);
      s = base_stim(); s.src = 1'b1; s.d1 = 32'h100; s.imm = 32'hFFFF_FFFC; s.rdst = 1'b0;
      run_alu("addi_neg", s);
      s = base_stim(); s.fa = 2'b10; s.ex = 32'd9; s.fb = 2'b01; s.mw = 32'd6;
      s.d1 = 32'd100; s.d2 = 32'd200;
      run_alu("fwd_ex_mw", s);
      s = base_stim(); s.fb = 2'b11; s.d1 = 32'd1; s.d2 = 32'h20; s.ex = 32'h77; s.mw = 32'h55;
      run_alu("fwd_b_11", s);
      s = base_stim(); s.op = 2'd2; s.imm = 32'h3f; s.d1 = 32'd3; s.d2 = 32'd4;
      run_alu("bad_funct", s);

      // Randomized single-cycle ops
      for (int i = 0; i < 120; i++) begin
         s.op   = 2'($urandom_range(3, 0));
         s.src  = 1'($urandom_range(1, 0));
         s.rdst = 1'($urandom_range(1, 0));
         s.d1   = $urandom; s.d2 = $urandom; s.ex = $urandom; s.mw = $urandom;
         s.fa   = 2'($urandom_range(3, 0));
         s.fb   = 2'($urandom_range(3, 0));
         s.rt   = 5'($urandom_range(31, 0));
         s.rd   = 5'($urandom_range(31, 0));
         s.imm  = $urandom;
         idx    = 3'($urandom_range(5, 0));
         if (idx != 3'd5) s.imm[5:0] = fpool[idx];
         if (s.op == 2'd2 && s.imm[5:0] == 6'h18) s.imm[5:0] = 6'h20;
         run_alu("rand", s);
      end

      // Multiply with forwarding inputs disturbed during BUSY
      @(posedge clk); #1;
      run_mul("mul_10000x10001", 32'h0001_0000, 32'h0001_0001, 1'b1);

      // Back-to-back: second mul enters right after DONE
      @(posedge clk); #1;
      run_mul("mul_7x6", 32'd7, 32'd6, 1'b0);
      @(posedge clk); #1;
      run_mul("mul_ffffffffx2", 32'hFFFF_FFFF, 32'd2, 1'b0);

      // Random multiplies
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         run_mul("mul_rand", $urandom, $urandom, 1'b1);
      end

      // Non-mul right after a multiply completes
      s = base_stim(); s.op = 2'd3; s.d1 = 32'hF0; s.d2 = 32'h0F;
      run_alu("or_after_mul", s);

      // Reset asserted mid-multiply
      @(posedge clk); #1;
      s = base_stim(); s.op = 2'd2; s.imm = 32'h18; s.d1 = 32'hDEAD_BEEF; s.d2 = 32'h0123_4567;
      apply(s);
      repeat (5) begin
         @(posedge clk); #1;
      end
      check_eq("midrst/busy_before", 32'(bus.mul_busy_o), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("midrst/busy", 32'(bus.mul_busy_o), 32'd0);
      check_eq("midrst/pcen", 32'(bus.pc_enable_o), 32'd1);
      check_eq("midrst/res", bus.result_o, 32'd0);
      @(posedge clk); #1;
      check_eq("midrst/busy_hold", 32'(bus.mul_busy_o), 32'd0);
      rst_n = 1'b1;
      run_mul("mul_3x4_after_rst", 32'd3, 32'd4, 1'b0);

      @(posedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
